port_uart_tx: RTL and testbench
===============================

PORT_UART_TX -- requirements
Module: port_uart_tx

Interface
REQ-001 The block SHALL have parameter CLKS_PER_BIT, default 434, clocks per serial bit (50 MHz / 115200 baud).
REQ-002 The block SHALL have parameter FIFO_DEPTH, default 4, transmit FIFO entries, power of two, 2..16.
REQ-003 The block SHALL have port clk  input  1  single system clock; all state changes on rising edge.
REQ-004 The block SHALL have port reset  input  1  asynchronous active-low reset.
REQ-005 The block SHALL have port MemWrite  input  1  processor store strobe, one cycle per store.
REQ-006 The block SHALL have port MemRead  input  1  processor load strobe.
REQ-007 The block SHALL have port Address  input  32  processor data address; only Address[3:2] decoded.
REQ-008 The block SHALL have port WriteData  input  32  store data; only [7:0] used.
REQ-009 The block SHALL have port ReadData  output  32  load data, combinational from Address[3:2].
REQ-010 The block SHALL have port TxSerial  output  1  UART line, idle high.
REQ-011 The block SHALL have port TxBusy  output  1  high while a frame is on the line or FIFO non-empty.

Function
REQ-012 Address[3:2]=0 (TXDATA) with MemWrite SHALL push WriteData[7:0] into the FIFO at the clock edge.
REQ-013 Address[3:2]=1 (STATUS) SHALL read {24'b0, count[3:0], overflow, empty, full, busy} in bits [31:0], LSB = busy.
REQ-014 Address[3:2]=0, 2 or 3 SHALL read 0; writes to 1..3 SHALL be ignored.
REQ-015 A push while full SHALL be dropped and set the sticky overflow flag; FIFO contents unchanged.
REQ-016 A MemRead of STATUS SHALL return current overflow and clear it at that clock edge; a simultaneous overflow event SHALL keep it set.
REQ-017 Push and pop in the same cycle SHALL both take effect; when full, the pop frees the slot and the push is accepted without overflow.
REQ-018 Read/write pointers SHALL wrap modulo FIFO_DEPTH; count SHALL range 0..FIFO_DEPTH.
REQ-019 The transmitter FSM SHALL have states IDLE, START, DATA, PARITY (only when compiled in), STOP.
REQ-020 IDLE: TxSerial=1; when FIFO non-empty, pop head into shift register and go to START next cycle.
REQ-021 START: TxSerial=0 for CLKS_PER_BIT cycles, then DATA.
REQ-022 DATA: 8 bits LSB first, each CLKS_PER_BIT cycles, bit counter 0..7; after bit 7 go to PARITY or STOP.
REQ-023 STOP: TxSerial=1 for CLKS_PER_BIT cycles, then IDLE; a non-empty FIFO SHALL start the next frame with exactly one IDLE cycle between frames.
REQ-024 Baud counter SHALL count 0..CLKS_PER_BIT-1 and restart on every state change; frame length SHALL be exactly 10*CLKS_PER_BIT (+CLKS_PER_BIT with parity) cycles.
REQ-025 TxBusy SHALL equal (state != IDLE) OR (FIFO non-empty).

Reset
REQ-026 reset low SHALL immediately force state IDLE, TxSerial=1, TxBusy=0, FIFO empty, count=0, pointers 0, overflow=0, counters 0.
REQ-027 reset asserted mid-frame SHALL abort the frame; queued bytes SHALL be discarded and not transmitted after release.
REQ-028 ReadData SHALL read STATUS = 32'h0000_0004 (empty only) while and immediately after reset.

Configuration
REQ-029 With macro PORT_UART_TX_PARITY_EN defined, a PARITY state SHALL follow DATA, sending even parity (XOR of the 8 data bits) for CLKS_PER_BIT cycles.
REQ-030 Without PORT_UART_TX_PARITY_EN, no PARITY state or logic SHALL exist and DATA SHALL go directly to STOP.

Verification
REQ-031 CLKS_PER_BIT=4, store 8'hA5 to TXDATA -> one IDLE cycle later line shows 0,1,0,1,0,0,1,0,1,1, each 4 cycles; TxBusy high 41 cycles.
REQ-032 FIFO_DEPTH=4, five back-to-back stores 01..05 while idle-blocked -> 01..04 transmitted in order, 05 dropped, STATUS bit3=1, next STATUS read returns bit3=0.
REQ-033 FIFO full and store coincides with IDLE pop -> store accepted, overflow stays 0, count stays 4.
REQ-034 reset pulled low during DATA bit 3 of 8'h3C with 2 bytes queued -> TxSerial=1 same cycle, STATUS=32'h4, no further frames after release.
REQ-035 PORT_UART_TX_PARITY_EN defined, send 8'h07 -> parity bit 1, frame 11*CLKS_PER_BIT cycles; 8'h03 -> parity bit 0.
REQ-036 Load from Address[3:2]=2 -> ReadData=0; store to Address[3:2]=3 -> FIFO count unchanged.

Source files
------------

// File: rtl/port_uart_tx.sv
// Memory-mapped UART transmitter: TXDATA/STATUS registers, small TX FIFO, 8N1 framing.
// Define PORT_UART_TX_PARITY_EN to insert an even-parity bit between data and stop.
module port_uart_tx #(
  parameter int CLKS_PER_BIT = 434,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemWrite,
  input  logic        MemRead,
  input  logic [31:0] Address,
  input  logic [31:0] WriteData,
  output logic [31:0] ReadData,
  output logic        TxSerial,
  output logic        TxBusy
);

  localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W  = PTR_W + 1;
  localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0]  DEPTH_CNT = CNT_W'(FIFO_DEPTH);

`ifdef PORT_UART_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

  state_t            state;
  logic [BAUD_W-1:0] baud_cnt;
  logic [2:0]        bit_idx;
  logic [7:0]        shift_reg;
  logic              tx_line;

  logic [7:0]        mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count;
  logic [3:0]        count4;
  logic              overflow;

  logic empty, full, push, pop, push_ok, overflow_evt, status_rd, baud_done;
  logic unused_bits;

  assign empty        = (count == '0);
  assign full         = (count == DEPTH_CNT);
  assign push         = MemWrite && (Address[3:2] == 2'd0);
  assign pop          = (state == IDLE) && !empty;
  // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
  assign push_ok      = push && (!full || pop);
  assign overflow_evt = push && full && !pop;
  assign status_rd    = MemRead && (Address[3:2] == 2'd1);
  assign baud_done    = (baud_cnt == BAUD_LAST);
  assign count4       = 4'(count);
  assign unused_bits  = ^{Address[31:4], Address[1:0], WriteData[31:8]};

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= WriteData[7:0];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push_ok, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      // A fresh overflow wins over the clear-on-read of STATUS.
      if (overflow_evt) begin
        overflow <= 1'b1;
      end else if (status_rd) begin
        overflow <= 1'b0;
      end
    end
  end

  // tx_line is loaded with the level of the state being entered, so it stays aligned with state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      baud_cnt  <= '0;
      bit_idx   <= '0;
      shift_reg <= '0;
      tx_line   <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          tx_line  <= 1'b1;
          baud_cnt <= '0;
          if (!empty) begin
            shift_reg <= mem[rd_ptr];
            tx_line   <= 1'b0;
            state     <= START;
          end
        end
        START: begin
          if (baud_done) begin
            baud_cnt <= '0;
            bit_idx  <= '0;
            tx_line  <= shift_reg[0];
            state    <= DATA;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        DATA: begin
          if (baud_done) begin
            baud_cnt <= '0;
            if (bit_idx == 3'd7) begin
`ifdef PORT_UART_TX_PARITY_EN
              tx_line <= ^shift_reg;
              state   <= PARITY;
`else
              tx_line <= 1'b1;
              state   <= STOP;
`endif
            end else begin
              bit_idx <= bit_idx + 1'b1;
              tx_line <= shift_reg[bit_idx + 3'd1];
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
`ifdef PORT_UART_TX_PARITY_EN
        PARITY: begin
          if (baud_done) begin
            baud_cnt <= '0;
            tx_line  <= 1'b1;
            state    <= STOP;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
`endif
        STOP: begin
          if (baud_done) begin
            baud_cnt <= '0;
            state    <= IDLE;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        default: begin
          baud_cnt <= '0;
          tx_line  <= 1'b1;
          state    <= IDLE;
        end
      endcase
    end
  end

  assign TxSerial = tx_line;
  assign TxBusy   = (state != IDLE) || !empty;

  always_comb begin
    ReadData = 32'h0;
    if (Address[3:2] == 2'd1) begin
      ReadData = {24'h0, count4, overflow, empty, full, TxBusy};
    end
  end

endmodule

// File: tb/tb_port_uart_tx.sv
// Bench for port_uart_tx: frame-level reference model checked every cycle, a line decoder,
// and directed register/FIFO/reset scenarios with literal expectations.
module tb_port_uart_tx;
  localparam int CPB   = 4;
  localparam int DEPTH = 4;
`ifdef PORT_UART_TX_PARITY_EN
  localparam int NSYM    = 11;
  localparam int LEN_EXP = 45;
  localparam logic [10:0] A5_LIT = 11'b10101001010;
`else
  localparam int NSYM    = 10;
  localparam int LEN_EXP = 41;
  localparam logic [10:0] A5_LIT = 11'b01101001010;
`endif
  localparam int FRAME = NSYM * CPB;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        MemWrite = 1'b0;
  logic        MemRead = 1'b0;
  logic [31:0] Address = 32'h0;
  logic [31:0] WriteData = 32'h0;
  logic [31:0] ReadData;
  logic        TxSerial;
  logic        TxBusy;

  int total = 0;
  int bad = 0;

  port_uart_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .MemWrite(MemWrite), .MemRead(MemRead),
    .Address(Address), .WriteData(WriteData), .ReadData(ReadData),
    .TxSerial(TxSerial), .TxBusy(TxBusy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  // Reference model: a byte queue plus a position inside the current frame's symbol list.
  byte unsigned     m_q[$];
  int               m_pos = -1;
  logic [NSYM-1:0]  m_sym = '1;
  logic             m_ovf = 1'b0;
  logic             m_idle, m_push, m_sread, m_ovf_ev;

  function automatic logic [NSYM-1:0] frame_of(input logic [7:0] d);
    logic [NSYM-1:0] s;
    s = '1;
    s[0] = 1'b0;
    for (int i = 0; i < 8; i++) s[i+1] = d[i];
`ifdef PORT_UART_TX_PARITY_EN
    s[9] = ^d;
`endif
    s[NSYM-1] = 1'b1;
    return s;
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_q.delete();
      m_pos = -1;
      m_ovf = 1'b0;
    end else begin
      m_idle  = (m_pos < 0);
      m_push  = MemWrite && (Address[3:2] == 2'd0);
      m_sread = MemRead && (Address[3:2] == 2'd1);
      if (!m_idle) begin
        m_pos++;
        if (m_pos == FRAME) m_pos = -1;
      end else if (m_q.size() > 0) begin
        m_sym = frame_of(m_q.pop_front());
        m_pos = 0;
      end
      m_ovf_ev = 1'b0;
      if (m_push) begin
        if (m_q.size() < DEPTH) m_q.push_back(WriteData[7:0]);
        else m_ovf_ev = 1'b1;
      end
      if (m_ovf_ev) m_ovf = 1'b1;
      else if (m_sread) m_ovf = 1'b0;
    end
  end

  function automatic logic exp_busy();
    return (m_pos >= 0) || (m_q.size() > 0);
  endfunction

  function automatic logic exp_line();
    return (m_pos < 0) ? 1'b1 : m_sym[m_pos / CPB];
  endfunction

  function automatic logic [31:0] exp_status();
    return {24'h0, 4'(m_q.size()), m_ovf, (m_q.size() == 0), (m_q.size() == DEPTH), exp_busy()};
  endfunction

  initial begin
    forever begin
      @(negedge clk);
      #2;
      chk("line", TxSerial, exp_line());
      chk("busy", TxBusy, exp_busy());
      chk("rdata", ReadData, (Address[3:2] == 2'd1) ? exp_status() : 32'h0);
    end
  end

  // Independent line decoder sampling the middle of each bit.
  byte unsigned rx_q[$];
  bit           rx_par[$];
  logic         rx_on = 1'b0;
  int           rx_t = 0;
  logic [7:0]   rx_b = 8'h0;
  logic         rx_p = 1'b0;
  logic         rx_last_par = 1'b0;

  always @(negedge clk) begin
    if (!reset) begin
      rx_on = 1'b0;
    end else if (!rx_on) begin
      if (TxSerial == 1'b0) begin
        rx_on = 1'b1;
        rx_t = 0;
      end
    end else begin
      rx_t++;
      for (int k = 0; k < 8; k++) if (rx_t == (k + 1) * CPB + CPB / 2) rx_b[k] = TxSerial;
      if (rx_t == 9 * CPB + CPB / 2) rx_p = TxSerial;
      if (rx_t == (NSYM - 1) * CPB + CPB / 2) begin
        rx_q.push_back(rx_b);
        rx_par.push_back(rx_p);
        rx_on = 1'b0;
      end
    end
  end

  function automatic int rx_get();
    if (rx_q.size() == 0) return 32'hFFFF;
    rx_last_par = rx_par.pop_front();
    return int'(rx_q.pop_front());
  endfunction

  task automatic cyc(input logic w, input logic r, input logic [31:0] a, input logic [7:0] d);
    MemWrite = w;
    MemRead = r;
    Address = a;
    WriteData = {24'hDEADBE, d};
    @(negedge clk);
    MemWrite = 1'b0;
    MemRead = 1'b0;
    Address = 32'h0;
    WriteData = 32'h0;
  endtask

  task automatic rd_status(input string name, input logic [31:0] exp);
    MemRead = 1'b1;
    Address = 32'h4;
    #1 chk(name, ReadData, exp);
    @(negedge clk);
    MemRead = 1'b0;
    Address = 32'h0;
  endtask

  task automatic wait_idle(input string name, input int lim);
    int n;
    n = 0;
    while (TxBusy && n < lim) begin
      @(negedge clk);
      n++;
    end
    chk(name, TxBusy, 1'b0);
    repeat (2) @(negedge clk);
  endtask

  logic smp [256];

  task automatic send_measure(input logic [7:0] d, output int n);
    cyc(1'b1, 1'b0, 32'h0, d);
    n = 0;
    while (TxBusy && n < 200) begin
      smp[n] = TxSerial;
      n++;
      @(negedge clk);
    end
    repeat (2) @(negedge clk);
  endtask

  byte unsigned exp_b[6] = '{8'h55, 8'h01, 8'h02, 8'h03, 8'h04, 8'h06};
  logic [63:0]  got_vec, exp_vec;
  int           n;

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset state
    Address = 32'h4;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_status", ReadData, 32'h4);
    chk("rst_line", TxSerial, 1'b1);
    chk("rst_busy", TxBusy, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    #1 chk("post_rst_status", ReadData, 32'h4);
    Address = 32'h0;
    @(negedge clk);

    // Single frame of 0xA5: one idle cycle, then the symbol pattern
    rx_q.delete();
    rx_par.delete();
    send_measure(8'hA5, n);
    chk("a5_busy_len", n, LEN_EXP);
    got_vec = '0;
    exp_vec = '0;
    for (int i = 0; i < n && i < 64; i++) got_vec[i] = smp[i];
    exp_vec[0] = 1'b1;
    for (int k = 0; k < NSYM; k++)
      for (int j = 0; j < CPB; j++) exp_vec[1 + k * CPB + j] = A5_LIT[k];
    chk("a5_pattern", got_vec, exp_vec);
    chk("a5_rx", rx_get(), 32'hA5);

    // Overflow while blocked, then full-FIFO push coinciding with the idle pop
    rx_q.delete();
    rx_par.delete();
    cyc(1'b1, 1'b0, 32'h0, 8'h55);
    for (int i = 1; i <= 5; i++) cyc(1'b1, 1'b0, 32'h0, 8'(i));
    rd_status("ovf_set", 32'h4B);
    rd_status("ovf_cleared", 32'h43);
    repeat (FRAME - 6) @(negedge clk);
    Address = 32'h4;
    #1 chk("full_before_pop", ReadData, 32'h43);
    cyc(1'b1, 1'b0, 32'h0, 8'h06);
    rd_status("push_on_pop", 32'h43);
    wait_idle("drain1", 400);
    chk("rx_count", rx_q.size(), 6);
    for (int i = 0; i < 6; i++) chk("rx_order", rx_get(), exp_b[i]);

    // Reset mid-frame with bytes queued
    rx_q.delete();
    rx_par.delete();
    cyc(1'b1, 1'b0, 32'h0, 8'h3C);
    cyc(1'b1, 1'b0, 32'h0, 8'hAA);
    cyc(1'b1, 1'b0, 32'h0, 8'hBB);
    repeat (16) @(negedge clk);
    Address = 32'h4;
    #1 reset = 1'b0;
    #1;
    chk("abort_line", TxSerial, 1'b1);
    chk("abort_busy", TxBusy, 1'b0);
    chk("abort_status", ReadData, 32'h4);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    #1 chk("release_status", ReadData, 32'h4);
    Address = 32'h0;
    repeat (120) @(negedge clk);
    chk("no_frames_after_abort", rx_q.size(), 0);

    // Address decode: reserved reads are zero, writes outside TXDATA ignored
    MemRead = 1'b1;
    Address = 32'h8;
    #1 chk("rd_addr2", ReadData, 32'h0);
    Address = 32'hC;
    #1 chk("rd_addr3", ReadData, 32'h0);
    MemRead = 1'b0;
    Address = 32'h0;
    @(negedge clk);
    cyc(1'b1, 1'b0, 32'hC, 8'h77);
    cyc(1'b1, 1'b0, 32'h4, 8'h66);
    cyc(1'b1, 1'b0, 32'h8, 8'h11);
    rd_status("ignored_writes", 32'h4);
    repeat (20) @(negedge clk);
    chk("ignored_no_tx", rx_q.size(), 0);

    // Parity cases (frame length and parity bit depend on the build)
    send_measure(8'h07, n);
    chk("len07", n, LEN_EXP);
    chk("rx07", rx_get(), 32'h07);
`ifdef PORT_UART_TX_PARITY_EN
    chk("par07", rx_last_par, 1'b1);
`endif
    send_measure(8'h03, n);
    chk("len03", n, LEN_EXP);
    chk("rx03", rx_get(), 32'h03);
`ifdef PORT_UART_TX_PARITY_EN
    chk("par03", rx_last_par, 1'b0);
`endif

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
